// File: rtl/wall_clock_pkg.sv
// wall_clock_pkg: shared FSM encodings, digit indices, wrap limits and reset times.
package wall_clock_pkg;
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        S_SEC   = 3'd1,
        S_DSEC  = 3'd2,
        S_MIN   = 3'd3,
        S_DMIN  = 3'd4,
        S_HOUR  = 3'd5,
        S_DHOUR = 3'd6
    } state_t;
    localparam int D_SEC = 0, D_DSEC = 1, D_MIN = 2, D_DMIN = 3, D_HOUR = 4, D_DHOUR = 5;
    localparam logic [3:0] LIM_UNIT = 4'd9, LIM_TENS = 4'd5;
    localparam logic [7:0] LIM_H24 = 8'h23, LIM_H12 = 8'h12;
    localparam logic [23:0] RST_24 = 24'h000000, RST_12 = 24'h120000;
    function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser, stability counter and one-cycle press pulse for an active-low key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic r_s0, r_s1, r_lvl, r_press;
    logic [CW-1:0] r_cnt;
    logic w_done;
    assign w_done = (r_s1 != r_lvl) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
            r_lvl   <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_s0    <= i_key_n;
            r_s1    <= r_s0;
            r_cnt   <= (r_s1 == r_lvl || w_done) ? '0 : r_cnt + CW'(1);
            r_lvl   <= w_done ? r_s1 : r_lvl;
            r_press <= w_done && !r_s1;
        end
    end
    assign o_press = r_press;
endmodule

// File: rtl/wall_clock_core.sv
// wall_clock_core: single-clock BCD wall clock with prescaler, set-mode FSM and blink mask.
// Optional alarm registers and output are enabled with WALL_CLOCK_ALARM_EN.
module wall_clock_core import wall_clock_pkg::*; #(
    parameter int TICKS_PER_SEC   = 50_000_000,
    parameter int BLINK_DIV       = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int MODE_24H        = 1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        select_n,
    input  logic        advance_n,
    input  logic        pause,
    output logic [23:0] digits,
    output logic [5:0]  blank,
    output logic [2:0]  sel_state,
    output logic        sec_pulse
`ifdef WALL_CLOCK_ALARM_EN
    ,
    input  logic        alarm_set,
    output logic        alarm
`endif
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [23:0] RST_T = (MODE_24H != 0) ? RST_24 : RST_12;
    state_t r_state, w_next;
    logic [23:0] r_t, w_tick;
    logic [PW-1:0] r_pre;
    logic [BW-1:0] r_bc;
    logic r_sp, r_ph, w_psel, w_padv, w_tc, w_set, w_adv;
    logic w_c0, w_c1, w_c2, w_c3;
    logic [5:0] w_blink;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .i_clk(CLOCK_50), .i_rst(reset), .i_key_n(select_n), .o_press(w_psel));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adv (
        .i_clk(CLOCK_50), .i_rst(reset), .i_key_n(advance_n), .o_press(w_padv));

    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        if (h == ((MODE_24H != 0) ? LIM_H24 : LIM_H12))
            return (MODE_24H != 0) ? 8'h00 : 8'h01;
        return (h[3:0] == LIM_UNIT) ? {h[7:4] + 4'd1, 4'd0} : {h[7:4], h[3:0] + 4'd1};
    endfunction

    // Per-digit edit without carry; in 12h mode both hour digits step the hour as a whole.
    function automatic logic [23:0] adv(input logic [23:0] t, input state_t s);
        logic [23:0] n;
        n = t;
        case (s)
            S_SEC:  n[D_SEC*4 +: 4]  = wrap_inc(t[D_SEC*4 +: 4], LIM_UNIT);
            S_DSEC: n[D_DSEC*4 +: 4] = wrap_inc(t[D_DSEC*4 +: 4], LIM_TENS);
            S_MIN:  n[D_MIN*4 +: 4]  = wrap_inc(t[D_MIN*4 +: 4], LIM_UNIT);
            S_DMIN: n[D_DMIN*4 +: 4] = wrap_inc(t[D_DMIN*4 +: 4], LIM_TENS);
            S_HOUR, S_DHOUR: begin
                if (MODE_24H == 0)
                    n[23:16] = hour_inc(t[23:16]);
                else if (s == S_HOUR)
                    n[D_HOUR*4 +: 4] = wrap_inc(t[D_HOUR*4 +: 4],
                        (t[D_DHOUR*4 +: 4] == LIM_H24[7:4]) ? LIM_H24[3:0] : LIM_UNIT);
                else begin
                    n[D_DHOUR*4 +: 4] = wrap_inc(t[D_DHOUR*4 +: 4], LIM_H24[7:4]);
                    if (n[D_DHOUR*4 +: 4] == LIM_H24[7:4] && t[D_HOUR*4 +: 4] > LIM_H24[3:0])
                        n[D_HOUR*4 +: 4] = LIM_H24[3:0];
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    assign w_tc  = (r_state == RUN) && !pause && (r_pre == PW'(TICKS_PER_SEC - 1));
    assign w_c0  = r_t[3:0] == LIM_UNIT;
    assign w_c1  = w_c0 && r_t[7:4] == LIM_TENS;
    assign w_c2  = w_c1 && r_t[11:8] == LIM_UNIT;
    assign w_c3  = w_c2 && r_t[15:12] == LIM_TENS;
    assign w_tick = {w_c3 ? hour_inc(r_t[23:16]) : r_t[23:16],
                     w_c2 ? wrap_inc(r_t[15:12], LIM_TENS) : r_t[15:12],
                     w_c1 ? wrap_inc(r_t[11:8], LIM_UNIT) : r_t[11:8],
                     w_c0 ? wrap_inc(r_t[7:4], LIM_TENS) : r_t[7:4],
                     wrap_inc(r_t[3:0], LIM_UNIT)};
    assign w_set = (r_state != RUN) && (r_state <= S_DHOUR) && w_padv && !w_psel;
`ifdef WALL_CLOCK_ALARM_EN
    assign w_adv = w_set && !alarm_set;
`else
    assign w_adv = w_set;
`endif

    assign w_next = (r_state > S_DHOUR) ? RUN :
                    !w_psel ? r_state :
                    (r_state == S_DHOUR) ? RUN : state_t'(r_state + 3'd1);

    always_ff @(posedge CLOCK_50) begin
        if (reset) r_state <= RUN;
        else r_state <= w_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_t   <= RST_T;
            r_pre <= '0;
            r_sp  <= 1'b0;
            r_bc  <= '0;
            r_ph  <= 1'b0;
        end else begin
            r_sp  <= w_tc;
            r_pre <= (r_state != RUN || w_tc) ? '0 : pause ? r_pre : r_pre + PW'(1);
            r_t   <= w_tc ? w_tick : w_adv ? adv(r_t, r_state) : r_t;
            r_bc  <= (r_bc == BW'(BLINK_DIV - 1)) ? '0 : r_bc + BW'(1);
            r_ph  <= r_ph ^ (r_bc == BW'(BLINK_DIV - 1));
        end
    end

`ifdef WALL_CLOCK_ALARM_EN
    logic [15:0] r_al;
    logic [23:0] w_al_adv;
    logic r_alarm;
    assign w_al_adv = adv({r_al, 8'h00}, r_state);
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_al    <= RST_T[23:8];
            r_alarm <= 1'b0;
        end else begin
            r_al    <= (w_set && alarm_set) ? w_al_adv[23:8] : r_al;
            r_alarm <= (w_psel || w_padv) ? 1'b0 :
                       (w_tc && w_tick[7:0] == 8'h00) ? (w_tick[23:8] == r_al) : r_alarm;
        end
    end
    assign alarm = r_alarm;
`endif

    assign w_blink   = (r_ph && r_state != RUN && r_state <= S_DHOUR) ?
                       (6'd1 << (3'(r_state) - 3'd1)) : 6'd0;
    assign blank     = w_blink | {(MODE_24H == 0) && (r_t[23:20] == 4'd0), 5'b0};
    assign digits    = r_t;
    assign sel_state = r_state;
    assign sec_pulse = r_sp;
endmodule

// File: doc/wall_clock_core.md
Name: wall_clock_core

Overview:
- Parametrised, single-clock successor to the board-level wall clock.
- One synchronous block replaces the ripple-clocked counter chain. It holds:
  - a tick prescaler;
  - a six-digit BCD time register with 12/24-hour mode;
  - a debounced select/advance set-mode FSM;
  - a per-digit blink mask.
- Sits between board keys/switches and the six hex-display decoders. All digit counters advance on CLOCK_50 enables; no derived clocks.

Parameters:
- TICKS_PER_SEC, 50_000_000, CLOCK_50 cycles per second; must be >= 2.
- BLINK_DIV, 25_000_000, cycles per blink half-period; must be >= 1.
- DEBOUNCE_CYCLES, 500_000, cycles a key level must stay stable before it is accepted.
- MODE_24H, 1, 1 = 00:00:00–23:59:59; 0 = 12-hour display, 01:00:00–12:59:59.

Ports:
- CLOCK_50  in  1  sole clock.
- reset  in  1  synchronous, active-high; clears all state.
- select_n  in  1  raw KEY, active-low: cycles through the digit to set.
- advance_n  in  1  raw KEY, active-low: increments the selected digit.
- pause  in  1  when high, the prescaler holds and time freezes.
- digits  out  24  BCD, [3:0]=seconds units … [23:20]=hours tens.
- blank  out  6  per-digit blank request; bit i high = display i dark.
- sel_state  out  3  current FSM state encoding.
- sec_pulse  out  1  one-cycle strobe on each counted second.

Behaviour:
- **Reset:**
  - 24h mode: digits = 00:00:00. 12h mode: digits = 12:00:00.
  - blank = 0, sel_state = RUN, sec_pulse = 0.
  - Prescaler, blink counter and debouncers clear.
  - Reset during set mode returns to RUN.
- **Key input:** each key passes through a 2-flop synchroniser and then a debouncer. A press is the first accepted high→low transition and yields one single-cycle pulse; holding the key gives no repeat.
- **FSM states:** RUN(0), S_SEC(1), S_DSEC(2), S_MIN(3), S_DMIN(4), S_HOUR(5), S_DHOUR(6).
  - A select pulse moves to the next state; S_DHOUR returns to RUN.
  - Encodings 7 and up are illegal and go to RUN.
- **RUN timing:**
  - When pause is low, the prescaler counts 0..TICKS_PER_SEC-1.
  - At terminal count: sec_pulse = 1 and time increments by one second in the same edge, with full carry chain.
    - Seconds and minutes wrap at 59.
    - Hours: 23→00 in 24h mode; 12→01 in 12h mode.
  - Visible latency from the terminal count to the digits update is one cycle.
- **Set states:**
  - The prescaler is held at 0, so time is frozen.
  - On return to RUN, a full second elapses before the first increment.
- **Advance pulse:** increments only the selected digit, with no carry into the neighbouring digit.
  - Seconds/minutes units: 9→0.
  - Seconds/minutes tens: 5→0.
  - Hours units in 24h mode: wrap at 9, or at 3 when hours tens = 2.
  - Hours tens in 24h mode: 2→0; moving to 2 clamps hours units to 3 when they exceed 3.
  - 12h mode: advancing either hour digit steps the hour value 1..12 as a whole (12→1).
  - An advance pulse in RUN is ignored.
- **Simultaneous select + advance:** select wins and advance is dropped.
- **Blink:**
  - The blink counter toggles a phase bit every BLINK_DIV cycles.
  - blank[i] = 1 only when digit i is selected and phase = 1. Otherwise blank = 0.
  - 12h mode: blank[5] is also forced to 1 whenever hours tens = 0 (leading-zero suppression).
- **Invariant:** the digits output is always a legal time.

Optional Feature:
- Macro: WALL_CLOCK_ALARM_EN.
- **Defined:**
  - Extra ports: alarm_set in 1 (while high, advance edits alarm registers instead of time) and alarm out 1.
  - Alarm registers reset to 00:00 in 24h mode, 12:00 in 12h mode.
  - alarm asserts for 60 s starting at the second where HH:MM:00 equals the alarm.
  - Any select or advance press clears alarm.
- **Absent:** no extra ports and no alarm logic.

Decomposition:
- Package wall_clock_pkg holds:
  - the FSM state enum and encodings;
  - BCD digit index constants;
  - wrap limits (9, 5, 23, 12);
  - reset-time constants for each mode.
- One sub-module, key_debounce, instantiated once per key: synchroniser, stability counter and falling-edge pulse.

Test Plan:
- Bench parameters: TICKS_PER_SEC=4, BLINK_DIV=2, DEBOUNCE_CYCLES=3.
- Carry chain, 24h: preload 23:59:58, run 8 cycles → sec_pulse twice, digits 00:00:00.
- Carry chain, 12h: preload 12:59:59, run 4 cycles → 01:00:00, blank[5]=1.
- Set flow, 24h: press select 5 times (S_HOUR), advance ×7 → hours 07; select → S_DHOUR, advance ×2 → hours 23 (units clamped from 7 to 3); select → RUN; time frozen throughout, first sec_pulse exactly 4 cycles after the return to RUN.
- Debounce: glitch advance_n low for 2 cycles in S_SEC → no change; hold low 10 cycles → exactly +1.
- Blink and pause, plus concurrency and reset:
  - In S_MIN, blank[2] toggles every 2 cycles and other bits stay 0.
  - pause=1 in RUN for 20 cycles → digits and prescaler unchanged.
  - Simultaneous select and advance pulses → state advances, digit unchanged.
  - reset asserted mid-set → RUN, 00:00:00.
